// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions,
// register encodings and the fetch sequencer state type.
package cpu_isa_pkg;

    localparam int ISA_INSTR_W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_SQA  = 4'b0110;
    localparam logic [3:0] OP_SQB  = 4'b0111;
    localparam logic [3:0] OP_PUSH = 4'b1000;
    localparam logic [3:0] OP_LDA  = 4'b1001;
    localparam logic [3:0] OP_LDB  = 4'b1010;
    localparam logic [3:0] OP_OUT  = 4'b1011;
    localparam logic [3:0] OP_BSHL = 4'b1100;
    localparam logic [3:0] OP_BSHR = 4'b1101;
    localparam logic [3:0] OP_RSV0 = 4'b1110;
    localparam logic [3:0] OP_RSV1 = 4'b1111;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int RA_MSB = 3;
    localparam int RA_LSB = 2;
    localparam int RB_MSB = 1;
    localparam int RB_LSB = 0;

    localparam logic [1:0] REG_R0 = 2'd0;
    localparam logic [1:0] REG_R1 = 2'd1;
    localparam logic [1:0] REG_R2 = 2'd2;
    localparam logic [1:0] REG_R3 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } seq_state_e;

    function automatic logic is_reserved_op(input logic [3:0] op);
        return (op == OP_RSV0) || (op == OP_RSV1);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits an instruction word into opcode and register fields.
// Shared between the fetch sequencer and the execute stage.
module instr_field_split
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W = ISA_INSTR_W
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic [1:0]         ra,
    output logic [1:0]         rb,
    output logic               is_reserved
);

    assign op          = instr[OP_MSB:OP_LSB];
    assign ra          = instr[RA_MSB:RA_LSB];
    assign rb          = instr[RB_MSB:RB_LSB];
    assign is_reserved = is_reserved_op(op);

endmodule

// File: rtl/prog_fetch_sequencer.sv
// Program counter and fetch/issue controller in front of the ROM.
// Optional SEQ_SINGLE_STEP_EN adds a step input gating each fetch.
module prog_fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int MAX_ADDR = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [1:0]         prog_sel,
    output logic [1:0]         rom_prog,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [3:0]         issue_op,
    output logic [1:0]         issue_ra,
    output logic [1:0]         issue_rb,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);

    seq_state_e         state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_rsv;
    logic               fetch_go;
    logic               at_last;
    logic               rom_rsv;

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign at_last  = (pc == LAST);
    assign rom_rsv  = is_reserved_op(rom_instr[OP_MSB:OP_LSB]);
    assign rom_addr = pc;

    instr_field_split #(.INSTR_W(INSTR_W)) u_split (
        .instr       (ir),
        .op          (issue_op),
        .ra          (issue_ra),
        .rb          (issue_rb),
        .is_reserved (ir_rsv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            rom_prog    <= 2'd0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else if (abort) begin
            state       <= S_IDLE;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        rom_prog <= prog_sel;
                        pc       <= '0;
                        done     <= 1'b0;
                        overrun  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_go) begin
                        ir <= rom_instr;
                        if (!rom_rsv) begin
                            issue_valid <= 1'b1;
                            state       <= S_ISSUE;
                        end else if (at_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            overrun <= 1'b1;
                            state   <= S_HALT;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        // OUT wins over overrun at the last address
                        if (issue_op == OP_OUT) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_HALT;
                        end else if (at_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            overrun <= 1'b1;
                            state   <= S_HALT;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_rsv;
    assign unused_rsv = ir_rsv;

endmodule

// File: tb/tb_prog_fetch_sequencer.sv
// Scoreboard bench for prog_fetch_sequencer with a small ROM model.
module tb_prog_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] prog_sel;
    logic [1:0] rom_prog;
    logic [7:0] rom_addr;
    logic [7:0] rom_instr;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] issue_op;
    logic [1:0] issue_ra;
    logic [1:0] issue_rb;
    logic       busy;
    logic       done;
    logic       overrun;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step;
    initial step = 1'b1;
`endif

    int total;
    int bad;
    logic [7:0] exp_q[$];

    prog_fetch_sequencer #(
        .ADDR_W   (8),
        .INSTR_W  (8),
        .MAX_ADDR (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .prog_sel    (prog_sel),
        .rom_prog    (rom_prog),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_ra    (issue_ra),
        .issue_rb    (issue_rb),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(
        input logic [1:0] p,
        input logic [7:0] a
    );
        logic [7:0] v;
        v = 8'h00;
        case (p)
            2'd0: case (a)
                8'd0: v = 8'h90;
                8'd1: v = 8'h51;
                8'd2: v = 8'hE0;
                8'd3: v = 8'h6A;
                8'd4: v = 8'hB0;
                default: v = 8'h00;
            endcase
            2'd1: case (a)
                8'd0: v = 8'h90;
                8'd1: v = 8'hB0;
                default: v = 8'h00;
            endcase
            2'd2: case (a)
                8'd0: v = 8'h01;
                8'd1: v = 8'h12;
                8'd2: v = 8'h23;
                8'd3: v = 8'h34;
                8'd4: v = 8'hC5;
                default: v = 8'h00;
            endcase
            default: case (a)
                8'd0: v = 8'h10;
                8'd1: v = 8'h20;
                8'd2: v = 8'h30;
                8'd3: v = 8'h40;
                8'd4: v = 8'hB0;
                default: v = 8'h00;
            endcase
        endcase
        return v;
    endfunction

    always_comb rom_instr = rom(rom_prog, rom_addr);

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready && !abort) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue_extra got=%0h want=none",
                         {issue_op, issue_ra, issue_rb});
            end else begin
                check("issue", {issue_op, issue_ra, issue_rb},
                      exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] p);
        start    = 1'b1;
        prog_sel = p;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        prog_sel    = 2'd0;
        issue_ready = 1'b1;
        total       = 0;
        bad         = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", issue_valid, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_prog", rom_prog, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // prog 1: LDA then OUT, ready held high
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hB0);
        go(2'd1);
        check("p1_busy", busy, 1);
        check("p1_prog", rom_prog, 1);
        check("p1_addr0", rom_addr, 0);
        repeat (3) tick();
        check("p1_done_early", done, 0);
        tick();
        check("p1_done", done, 1);
        check("p1_busy_off", busy, 0);
        check("p1_ovr", overrun, 0);
        check("p1_addr_end", rom_addr, 1);
        tick();
        check("p1_addr_hold", rom_addr, 1);

        // prog 0: backpressure then a reserved opcode at addr 2
        issue_ready = 1'b0;
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h6A);
        exp_q.push_back(8'hB0);
        go(2'd0);
        check("p1_done_clr", done, 0);
        tick();
        check("p0_valid", issue_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p0_hold_v", issue_valid, 1);
            check("p0_hold_f",
                  {issue_op, issue_ra, issue_rb}, 8'h90);
            check("p0_hold_pc", rom_addr, 0);
        end
        issue_ready = 1'b1;
        tick();
        check("p0_addr1", rom_addr, 1);
        check("p0_vfall", issue_valid, 0);
        tick();
        tick();
        check("p0_addr2", rom_addr, 2);
        tick();
        check("p0_rsv_addr3", rom_addr, 3);
        check("p0_rsv_noiss", issue_valid, 0);
        tick();
        check("p0_iss3", {issue_op, issue_ra, issue_rb}, 8'h6A);
        wait_done();
        check("p0_ovr", overrun, 0);
        check("p0_addr_end", rom_addr, 4);

        // prog 2: no OUT, runs into MAX_ADDR
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'hC5);
        go(2'd2);
        wait_done();
        check("p2_ovr", overrun, 1);
        check("p2_addr", rom_addr, 4);
        tick();
        check("p2_addr_hold", rom_addr, 4);
        check("p2_ovr_hold", overrun, 1);

        // start ignored in ISSUE, then async reset
        issue_ready = 1'b0;
        go(2'd3);
        tick();
        check("r_valid", issue_valid, 1);
        go(2'd0);
        check("r_prog_kept", rom_prog, 3);
        check("r_pc_kept", rom_addr, 0);
        check("r_still_v", issue_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async_v", issue_valid, 0);
        check("r_async_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("r_idle_busy", busy, 0);
        check("r_idle_v", issue_valid, 0);
        check("r_idle_prog", rom_prog, 0);

        // abort together with a handshake at pc=2
        issue_ready = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        go(2'd3);
        repeat (5) tick();
        check("a_valid", issue_valid, 1);
        check("a_pc2", rom_addr, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("a_busy", busy, 0);
        check("a_valid_off", issue_valid, 0);
        check("a_done", done, 0);
        check("a_pc_kept", rom_addr, 2);
        tick();
        check("a_idle_v", issue_valid, 0);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hB0);
        go(2'd3);
        check("a_restart", rom_addr, 0);
        wait_done();
        check("a_out_last", overrun, 0);
        check("a_addr_end", rom_addr, 4);

        tick();
        check("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
